// File: rtl/color_palette_ctrl.sv
// Colour palette editor: press/hold channel stepping over NUM_TARGETS RGB slots.
// Define COLOR_AUTOREPEAT_EN to enable hold-to-repeat stepping.
module color_palette_ctrl #(
  parameter  int CH_BITS     = 3,
  parameter  int NUM_TARGETS = 2,
  parameter  int WRAP        = 0,
  parameter  int HOLD_CYC    = 8,
  parameter  int REPEAT_CYC  = 4,
  localparam int SEL_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [SEL_W-1:0]                select,
  input  logic [2:0]                      rgbEn,
  input  logic                            dir,
  output logic [NUM_TARGETS*3*CH_BITS-1:0] rgbBus,
  output logic                            stepPulse
);

  localparam int TW      = 3 * CH_BITS;
  localparam int BW      = NUM_TARGETS * TW;
  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [BW-1:0] BUS_RST = BW'({TW{1'b1}});

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [2:0]         mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         prev_q;
  logic               arm_q;
  logic [BW-1:0]      bus_q, bus_d;
  logic               pulse_q, pulse_d;

  logic               press;
  logic               do_step;
  logic [SEL_W-1:0]   tsel;
  logic [2:0]         tmask;

  function automatic logic [CH_BITS-1:0] step_ch(
    input logic [CH_BITS-1:0] v,
    input logic               up
  );
    logic [CH_BITS-1:0] top;
    top = '1;
    if (up) begin
      if (v == top && WRAP == 0) return v;
      return v + CH_BITS'(1);
    end
    if (v == '0 && WRAP == 0) return v;
    return v - CH_BITS'(1);
  endfunction

  // arm_q blocks a press until rgbEn has been seen idle after reset
  assign press = arm_q && (rgbEn != 3'b000) && (prev_q == 3'b000);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    cnt_d   = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    do_step = 1'b0;
    tsel    = sel_q;
    tmask   = mask_q;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          do_step = 1'b1;
          tsel    = select;
          tmask   = rgbEn;
          sel_d   = select;
          mask_d  = rgbEn;
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (rgbEn == 3'b000) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`ifdef COLOR_AUTOREPEAT_EN
        else if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          do_step = 1'b1;
          state_d = REPEAT;
          cnt_d   = '0;
        end
`endif
      end
      REPEAT: begin
        if (rgbEn == 3'b000) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`ifdef COLOR_AUTOREPEAT_EN
        else if (cnt_q == CNT_W'(REPEAT_CYC - 1)) begin
          do_step = 1'b1;
          cnt_d   = '0;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus_d = bus_q;
    if (do_step && (32'(tsel) < NUM_TARGETS)) begin
      for (int t = 0; t < NUM_TARGETS; t++) begin
        if (32'(tsel) == t) begin
          for (int c = 0; c < 3; c++) begin
            if (tmask[c]) begin
              bus_d[t*TW + c*CH_BITS +: CH_BITS] =
                step_ch(bus_q[t*TW + c*CH_BITS +: CH_BITS], dir);
            end
          end
        end
      end
    end
    pulse_d = (bus_d != bus_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      prev_q  <= '0;
      arm_q   <= 1'b0;
      bus_q   <= BUS_RST;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      prev_q  <= rgbEn;
      arm_q   <= arm_q | (rgbEn == 3'b000);
      bus_q   <= bus_d;
      pulse_q <= pulse_d;
    end
  end

  assign rgbBus    = bus_q;
  assign stepPulse = pulse_q;

endmodule

// File: tb/tb_color_palette_ctrl.sv
// Bench for color_palette_ctrl: saturating and wrapping instances vs a
// press-age reference model, directed scenarios then random traffic.
module tb_color_palette_ctrl;

`ifdef COLOR_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [2:0]  en;
  logic        dir;
  logic [17:0] busA;
  logic [26:0] busB;
  logic        pA, pB;

  int nchk = 0;
  int nerr = 0;

  int mcol [2][4][3];
  int nt   [2] = '{2, 3};
  int wrp  [2] = '{0, 1};
  bit mheld[2];
  int mage [2];
  int mlsel[2];
  int mlmsk[2];
  bit marm [2];
  int mprev[2];
  bit mpul [2];

  always #5 clk = ~clk;

  color_palette_ctrl #(.CH_BITS(3), .NUM_TARGETS(2), .WRAP(0)) dA (
    .clk(clk), .reset(rst), .select(sel[0]), .rgbEn(en), .dir(dir),
    .rgbBus(busA), .stepPulse(pA)
  );

  color_palette_ctrl #(.CH_BITS(3), .NUM_TARGETS(3), .WRAP(1)) dB (
    .clk(clk), .reset(rst), .select(sel), .rgbEn(en), .dir(dir),
    .rgbBus(busB), .stepPulse(pB)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] mbus(input int i);
    logic [26:0] b;
    b = '0;
    for (int t = 0; t < nt[i]; t++)
      for (int c = 0; c < 3; c++)
        b[t*9 + c*3 +: 3] = 3'(mcol[i][t][c]);
    return b;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int s, ts, tm, v, nv;
      bit st, chg;
      s  = (i == 0) ? int'(sel[0]) : int'(sel);
      st = 0; ts = 0; tm = 0; chg = 0;
      if (rst) begin
        for (int t = 0; t < 4; t++)
          for (int c = 0; c < 3; c++)
            mcol[i][t][c] = (t == 0) ? 7 : 0;
        mheld[i] = 0; marm[i] = 0; mprev[i] = 0; mpul[i] = 0;
        continue;
      end
      if (mheld[i]) begin
        if (en == 0) mheld[i] = 0;
        else begin
          mage[i]++;
          if (AR && mage[i] >= HOLD && (mage[i] - HOLD) % REP == 0) begin
            st = 1; ts = mlsel[i]; tm = mlmsk[i];
          end
        end
      end else if (en != 0 && mprev[i] == 0 && marm[i]) begin
        mheld[i] = 1; mage[i] = 0;
        mlsel[i] = s; mlmsk[i] = int'(en);
        st = 1; ts = s; tm = int'(en);
      end
      if (en == 0) marm[i] = 1;
      mprev[i] = int'(en);
      if (st && ts < nt[i]) begin
        for (int c = 0; c < 3; c++) begin
          if (tm[c]) begin
            v  = mcol[i][ts][c];
            nv = dir ? v + 1 : v - 1;
            if (nv > 7 || nv < 0) nv = wrp[i] ? (nv & 7) : v;
            if (nv != v) chg = 1;
            mcol[i][ts][c] = nv;
          end
        end
      end
      mpul[i] = chg;
    end
  endtask

  task automatic tick();
    logic [26:0] ea, eb;
    @(posedge clk);
    model_step();
    #1;
    ea = mbus(0);
    eb = mbus(1);
    chk("busA", 32'(busA), 32'(ea[17:0]));
    chk("pulseA", 32'(pA), 32'(mpul[0]));
    chk("busB", 32'(busB), 32'(eb));
    chk("pulseB", 32'(pB), 32'(mpul[1]));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0; en = 3'b000; dir = 1'b1;
    ticks(2);
    chk("rst_busA", 32'(busA), 32'h001FF);
    chk("rst_pulseA", 32'(pA), 32'h0);
    rst = 1'b0;
    ticks(2);

    // single press on background red
    sel = 2'd1; en = 3'b001; dir = 1'b1;
    tick();
    chk("bg_red", 32'(busA[11:9]), 32'd1);
    chk("bg_pulse", 32'(pA), 32'd1);
    chk("t0_keep", 32'(busA[8:0]), 32'h1FF);
    ticks(2);
    chk("bg_pulse_drop", 32'(pA), 32'd0);
    en = 3'b000;
    ticks(2);

    // white + up: saturate on A, wrap on B
    sel = 2'd0; en = 3'b111; dir = 1'b1;
    tick();
    chk("sat_pulse", 32'(pA), 32'd0);
    chk("sat_t0", 32'(busA[8:0]), 32'h1FF);
    chk("wrap_t0", 32'(busB[8:0]), 32'h0);
    chk("wrap_pulse", 32'(pB), 32'd1);
    en = 3'b000;
    ticks(2);

    // long hold on background green, then release
    sel = 2'd1; en = 3'b010; dir = 1'b1;
    ticks(20);
    en = 3'b000;
    ticks(4);
    chk("bg_green", 32'(busA[14:12]), AR ? 32'd4 : 32'd1);

    // select/mask change mid-hold is ignored
    sel = 2'd1; en = 3'b010;
    tick();
    sel = 2'd0; en = 3'b011;
    ticks(5);
    en = 3'b000;
    ticks(2);
    chk("mid_t0", 32'(busA[8:0]), 32'h1FF);
    chk("mid_green", 32'(busA[14:12]), AR ? 32'd5 : 32'd2);
    chk("mid_red", 32'(busA[11:9]), 32'd1);

    // out-of-range target on the three-slot instance
    sel = 2'd3; en = 3'b111; dir = 1'b0;
    ticks(3);
    en = 3'b000;
    ticks(2);

    // reset in the middle of a long hold
    sel = 2'd1; en = 3'b100; dir = 1'b1;
    ticks(14);
    rst = 1'b1;
    tick();
    chk("mrst_bus", 32'(busA), 32'h001FF);
    chk("mrst_pulse", 32'(pA), 32'd0);
    rst = 1'b0;
    ticks(12);
    chk("mrst_held", 32'(busA), 32'h001FF);
    en = 3'b000;
    ticks(2);

    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 9) == 0)
        en = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      sel = 2'($urandom_range(0, 3));
      dir = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
